// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl
//   Control FSM for a multicycle RV32I core. It sequences fetch, decode,
//   execute, memory and writeback over one shared memory and one ALU, drives
//   the datapath select lines, selects the immediate format, and decodes the
//   ALU function.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   opcode      instr[6:0] from the instruction register
//   funct3      instr[14:12]
//   funct7b5    instr[30]
//   zero        ALU zero flag
//   mem_ready   memory returned data / accepted the access this cycle
//   PCWrite     PC register enable
//   AdrSrc      memory address select: 0=PC, 1=ALUResult register
//   MemWrite    memory write strobe
//   IRWrite     instruction register / OldPC enable
//   ResultSrc   00=ALUOut, 01=Data, 10=ALUResult
//   ALUSrcA     00=PC, 01=OldPC, 10=rs1 data
//   ALUSrcB     00=rs2 data, 01=ImmExt, 10=constant 4
//   ALUControl  000 add, 001 sub, 010 and, 011 or, 101 slt
//   ImmSrc      00=I, 01=S, 10=B, 11=J
//   RegWrite    register file write enable
//   state       current state, for debug/verification
module multicycle_ctrl #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [1:0] ImmSrc,
  output logic       RegWrite,
  output logic [3:0] state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  logic [3:0] state_q, state_d;
  logic       pc_update;
  logic       branch;
  logic [1:0] alu_op;

  assign state = state_q;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= RESET_STATE;
    else        state_q <= state_d;
  end

  // Next-state logic; illegal codes 11-15 fall back to FETCH
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_R:         state_d = S_EXECUTER;
          OP_I:         state_d = S_EXECUTEI;
          OP_JAL:       state_d = S_JAL;
          OP_BEQ:       state_d = S_BEQ;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = S_FETCH;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BEQ:      state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Moore output decode. Write strobes are qualified with rst_n so nothing
  // is written in a cycle where reset is being applied.
  always_comb begin
    AdrSrc    = 1'b0;
    MemWrite  = 1'b0;
    IRWrite   = 1'b0;
    ResultSrc = 2'b00;
    ALUSrcA   = 2'b00;
    ALUSrcB   = 2'b00;
    RegWrite  = 1'b0;
    pc_update = 1'b0;
    branch    = 1'b0;
    alu_op    = 2'b00;
    case (state_q)
      S_FETCH: begin
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready & rst_n;
        pc_update = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: AdrSrc = 1'b1;
      S_MEMWB: begin
        ResultSrc = 2'b01;
        RegWrite  = rst_n;
      end
      S_MEMWRITE: begin
        AdrSrc   = 1'b1;
        MemWrite = rst_n;
      end
      S_EXECUTER: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b10;
      end
      S_EXECUTEI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        alu_op  = 2'b10;
      end
      S_ALUWB: RegWrite = rst_n;
      S_BEQ: begin
        ALUSrcA = 2'b10;
        alu_op  = 2'b01;
        branch  = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      default: ;
    endcase
  end

  // PC enable follows zero combinationally so beq resolves in one cycle
  assign PCWrite = rst_n & (pc_update | (branch & zero));

  // Immediate format depends only on the opcode, not on state
  always_comb begin
    case (opcode)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // ALU decode; opcode[5] separates R-type sub from addi with imm[10] set
  always_comb begin
    ALUControl = 3'b000;
    case (alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (opcode[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       mem_ready;
  logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0] ALUControl;
  logic [3:0] state;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_STATE(4'd0)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ImmSrc(ImmSrc),
    .RegWrite(RegWrite), .state(state)
  );

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bring the FSM to FETCH with reset released
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; mem_ready = 1'b1; opcode = 7'b0110011;
    funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      vec_cnt++;
      if (state !== 4'd0) begin err_cnt++; $display("FAIL reset_state: got %0d want 0", state); end
      vec_cnt++;
      if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
        err_cnt++; $display("FAIL reset_strobes: got %b want 0000", {PCWrite, IRWrite, MemWrite, RegWrite});
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if (state !== 4'd1) begin err_cnt++; $display("FAIL reset_release: got %0d want 1", state); end
    #4;
  endtask

  task automatic test_lw();
    logic [3:0] exp_s [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    do_reset();
    opcode = 7'b0000011; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (state !== exp_s[i]) begin err_cnt++; $display("FAIL lw_state[%0d]: got %0d want %0d", i, state, exp_s[i]); end
      vec_cnt++;
      if (ImmSrc !== 2'b00) begin err_cnt++; $display("FAIL lw_immsrc: got %b want 00", ImmSrc); end
      vec_cnt++;
      if (RegWrite !== (exp_s[i] == 4'd4)) begin err_cnt++; $display("FAIL lw_regwrite[%0d]: got %b", i, RegWrite); end
      if (exp_s[i] == 4'd4) begin
        vec_cnt++;
        if (ResultSrc !== 2'b01) begin err_cnt++; $display("FAIL lw_resultsrc: got %b want 01", ResultSrc); end
      end
      if (exp_s[i] == 4'd3) begin
        vec_cnt++;
        if (AdrSrc !== 1'b1) begin err_cnt++; $display("FAIL lw_adrsrc: got %b want 1", AdrSrc); end
      end
      tick();
    end
  endtask

  task automatic test_sw();
    logic [3:0] exp_s [7] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd5, 4'd0};
    do_reset();
    opcode = 7'b0100011;
    for (int i = 0; i < 7; i++) begin
      mem_ready = (i >= 2);
      @(negedge clk);
      vec_cnt++;
      if (state !== exp_s[i]) begin err_cnt++; $display("FAIL sw_state[%0d]: got %0d want %0d", i, state, exp_s[i]); end
      vec_cnt++;
      if (ImmSrc !== 2'b01) begin err_cnt++; $display("FAIL sw_immsrc: got %b want 01", ImmSrc); end
      vec_cnt++;
      if (MemWrite !== (exp_s[i] == 4'd5)) begin err_cnt++; $display("FAIL sw_memwrite[%0d]: got %b", i, MemWrite); end
      vec_cnt++;
      if (IRWrite !== (exp_s[i] == 4'd0 && mem_ready)) begin err_cnt++; $display("FAIL sw_irwrite[%0d]: got %b", i, IRWrite); end
      vec_cnt++;
      if (PCWrite !== (exp_s[i] == 4'd0 && mem_ready)) begin err_cnt++; $display("FAIL sw_pcwrite[%0d]: got %b", i, PCWrite); end
      if (exp_s[i] == 4'd5) begin
        vec_cnt++;
        if (AdrSrc !== 1'b1) begin err_cnt++; $display("FAIL sw_adrsrc: got %b want 1", AdrSrc); end
      end
      tick();
    end
  endtask

  // One ALU instruction: FETCH, DECODE, EXECUTE(R/I), ALUWB, FETCH
  task automatic test_alu(input logic [6:0] op, input logic [2:0] f3,
                          input logic f7, input logic [2:0] exp_ctl);
    logic [3:0] exp_exec;
    exp_exec = (op == 7'b0110011) ? 4'd6 : 4'd7;
    do_reset();
    opcode = op; funct3 = f3; funct7b5 = f7; mem_ready = 1'b1;
    tick();
    @(negedge clk);
    vec_cnt++;
    if (ALUControl !== 3'b000) begin err_cnt++; $display("FAIL alu_decode_add: got %b want 000", ALUControl); end
    tick();
    @(negedge clk);
    vec_cnt++;
    if (state !== exp_exec) begin err_cnt++; $display("FAIL alu_exec_state: got %0d want %0d", state, exp_exec); end
    vec_cnt++;
    if (ALUControl !== exp_ctl) begin err_cnt++; $display("FAIL alu_ctl op=%b f3=%b: got %b want %b", op, f3, ALUControl, exp_ctl); end
    tick();
    @(negedge clk);
    vec_cnt++;
    if (state !== 4'd8 || RegWrite !== 1'b1 || ResultSrc !== 2'b00) begin
      err_cnt++; $display("FAIL alu_wb: got state %0d rw %b rs %b want 8 1 00", state, RegWrite, ResultSrc);
    end
    tick();
    @(negedge clk);
    vec_cnt++;
    if (state !== 4'd0) begin err_cnt++; $display("FAIL alu_return: got %0d want 0", state); end
    funct3 = 3'b000; funct7b5 = 1'b0;
  endtask

  task automatic test_beq(input logic z);
    do_reset();
    opcode = 7'b1100011; mem_ready = 1'b1; zero = z;
    tick();
    tick();
    @(negedge clk);
    vec_cnt++;
    if (state !== 4'd9) begin err_cnt++; $display("FAIL beq_state: got %0d want 9", state); end
    vec_cnt++;
    if (PCWrite !== z) begin err_cnt++; $display("FAIL beq_pcwrite z=%b: got %b want %b", z, PCWrite, z); end
    vec_cnt++;
    if (ImmSrc !== 2'b10) begin err_cnt++; $display("FAIL beq_immsrc: got %b want 10", ImmSrc); end
    vec_cnt++;
    if (ALUControl !== 3'b001) begin err_cnt++; $display("FAIL beq_aluctl: got %b want 001", ALUControl); end
    tick();
    @(negedge clk);
    vec_cnt++;
    if (state !== 4'd0) begin err_cnt++; $display("FAIL beq_return: got %0d want 0", state); end
    zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [3:0] exp_s [5] = '{4'd0, 4'd1, 4'd10, 4'd8, 4'd0};
    do_reset();
    opcode = 7'b1101111; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (state !== exp_s[i]) begin err_cnt++; $display("FAIL jal_state[%0d]: got %0d want %0d", i, state, exp_s[i]); end
      vec_cnt++;
      if (ImmSrc !== 2'b11) begin err_cnt++; $display("FAIL jal_immsrc: got %b want 11", ImmSrc); end
      vec_cnt++;
      if (PCWrite !== (exp_s[i] == 4'd0 || exp_s[i] == 4'd10)) begin
        err_cnt++; $display("FAIL jal_pcwrite[%0d]: got %b", i, PCWrite);
      end
      tick();
    end
  endtask

  task automatic test_unsupported();
    logic [3:0] exp_s [3] = '{4'd0, 4'd1, 4'd0};
    do_reset();
    opcode = 7'b1110011; mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (state !== exp_s[i]) begin err_cnt++; $display("FAIL unsup_state[%0d]: got %0d want %0d", i, state, exp_s[i]); end
      vec_cnt++;
      if (ImmSrc !== 2'b00) begin err_cnt++; $display("FAIL unsup_immsrc: got %b want 00", ImmSrc); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    opcode = 7'b0000011; mem_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    vec_cnt++;
    if (state !== 4'd3) begin err_cnt++; $display("FAIL mid_memread: got %0d want 3", state); end
    rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({PCWrite, IRWrite, MemWrite, RegWrite} !== 4'b0000) begin
      err_cnt++; $display("FAIL mid_strobes: got %b want 0000", {PCWrite, IRWrite, MemWrite, RegWrite});
    end
    @(posedge clk);
    @(negedge clk);
    vec_cnt++;
    if (state !== 4'd0) begin err_cnt++; $display("FAIL mid_reset_state: got %0d want 0", state); end
    vec_cnt++;
    if ({PCWrite, IRWrite, RegWrite} !== 3'b000) begin
      err_cnt++; $display("FAIL mid_reset_nowrite: got %b want 000", {PCWrite, IRWrite, RegWrite});
    end
    rst_n = 1'b1;
    #1;
    vec_cnt++;
    if (IRWrite !== 1'b1) begin err_cnt++; $display("FAIL mid_release_irwrite: got %b want 1", IRWrite); end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_alu(7'b0110011, 3'b000, 1'b1, 3'b001); // sub
    test_alu(7'b0010011, 3'b000, 1'b1, 3'b000); // addi, imm[10]=1
    test_alu(7'b0110011, 3'b010, 1'b0, 3'b101); // slt
    test_alu(7'b0010011, 3'b110, 1'b0, 3'b011); // ori
    test_alu(7'b0110011, 3'b111, 1'b0, 3'b010); // and
    test_alu(7'b0110011, 3'b001, 1'b0, 3'b000); // unlisted funct3 -> add
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal();
    test_unsupported();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Multicycle control FSM for the RV32I core: sequences fetch/decode/execute/writeback over a shared memory and ALU. It drives the datapath select lines, including ImmSrc to the immediate extender, and performs ALU function decode. Supported opcodes: lw, sw, R-type, I-type ALU, beq, jal. The fetch and load-read states wait for a memory ready handshake.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  synchronous active-low reset
opcode  in  7  instr[6:0] from the instruction register
funct3  in  3  instr[14:12]
funct7b5  in  1  instr[30]
zero  in  1  ALU zero flag
mem_ready  in  1  memory has data/accepted access this cycle
PCWrite  out  1  PC register enable
AdrSrc  out  1  memory address select: 0=PC, 1=ALUResult register
MemWrite  out  1  memory write strobe
IRWrite  out  1  instruction register / OldPC enable
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
ALUSrcA  out  2  00=PC, 01=OldPC, 10=rs1 data
ALUSrcB  out  2  00=rs2 data, 01=ImmExt, 10=constant 4
ALUControl  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ImmSrc  out  2  00=I, 01=S, 10=B, 11=J
RegWrite  out  1  register file write enable
state  out  4  current state, for debug/verification

Behaviour:
- All state updates occur on the rising edge of clk. The rst_n sample is synchronous: rst_n=0 forces state=FETCH on the next edge and overrides every transition.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11-15 are illegal; they go to FETCH on the next edge, and outputs take the default set while in them.
- Outputs are Moore, decoded from state. There are two exceptions:
  - PCWrite is combinational: PCUpdate | (Branch & zero).
  - ALUControl is combinational from ALUOp, funct3, funct7b5 and opcode[5].
- Default output set (every state unless overridden): all enables 0, selects 00, ALUOp=00, ImmSrc from opcode.
- ImmSrc from opcode, independent of state: 0000011 and 0010011 give 00; 0100011 gives 01; 1100011 gives 10; 1101111 gives 11; anything else gives 00.
- Outputs during reset: state=0 (FETCH), so the FETCH output set is visible during reset. The PCUpdate and IRWrite terms are held low while rst_n=0, so PCWrite=0 and IRWrite=0 during reset.
- Per-state outputs and transitions:
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10. IRWrite=mem_ready and PCUpdate=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target computation). Next state by opcode:
    - lw or sw: MEMADR
    - R-type (0110011): EXECUTER
    - I-type ALU (0010011): EXECUTEI
    - jal: JAL
    - beq: BEQ
    - any other opcode: FETCH (unsupported instructions are treated as no-ops)
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD for lw, MEMWRITE for sw.
  - MEMREAD: ResultSrc=00, AdrSrc=1. Stay while mem_ready=0; go to MEMWB when mem_ready=1.
  - MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
  - MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1. One cycle, no wait. Go to FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Go to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Go to ALUWB.
- ALU decode:
  - ALUOp 00: add. ALUOp 01: sub.
  - ALUOp 10, by funct3:
    - 000: sub if (opcode[5] & funct7b5), else add
    - 010: slt
    - 110: or
    - 111: and
    - any other funct3: add
  - ALUOp 11: add.
- Instruction latencies, fetch to return to FETCH, with mem_ready always 1: lw 5 cycles, sw 4, R/I 4, jal 4, beq 3. Each mem_ready=0 cycle adds one.
- Reset mid-instruction: any state goes to FETCH on the next edge. No write strobe (MemWrite, RegWrite, PCWrite) is asserted in the reset cycle.

Test Plan:
1. Reset: hold rst_n=0 for 3 cycles, then release with mem_ready=1 and opcode=0110011 -> state=0 while held; PCWrite=IRWrite=MemWrite=RegWrite=0; state=1 one cycle after release.
2. lw (opcode 0000011), mem_ready=1 -> states 0,1,2,3,4,0. ImmSrc=00 throughout. RegWrite=1 only in state 4, with ResultSrc=01.
3. sw (0100011), with mem_ready held 0 for 2 cycles in FETCH -> FETCH held 3 cycles, then 1,2,5,0. ImmSrc=01. MemWrite=1 only in state 5, with AdrSrc=1.
4. R-type sub (funct3=000, funct7b5=1) -> ALUControl=001 in EXECUTER. Then addi with funct7b5=1 (opcode 0010011) -> ALUControl=000. slt (funct3=010) -> ALUControl=101.
5. beq (1100011): zero=1 -> PCWrite=1 in BEQ and ImmSrc=10. Repeat with zero=0 -> PCWrite=0. Both cases return to FETCH.
6. jal (1101111) -> states 0,1,10,8,0, ImmSrc=11, PCWrite=1 in JAL. Unsupported opcode 1110011 -> DECODE returns directly to FETCH. Pulse rst_n low during MEMREAD -> state=0 next edge, with no RegWrite.
